// File: rtl/mfsk_mod.sv
// M-ary FSK modulator: phase-accumulator tone generator with 1-bit I/Q sign outputs.
// Symbols come from an internal Fibonacci LFSR or from an external valid/ready stream.
module mfsk_mod #(
    parameter int unsigned       CLK_DIV    = 1,
    parameter int unsigned       SYM_LEN    = 128,
    parameter int unsigned       BPS        = 1,
    parameter int unsigned       LFSR_W     = 5,
    parameter logic [LFSR_W-1:0] LFSR_TAPS  = 5'b10100,
    parameter logic [LFSR_W-1:0] SEED       = 5'b00001,
    parameter int unsigned       PHASE_W    = 8,
    parameter int unsigned       BASE_INC   = 8,
    parameter int unsigned       STEP_INC   = 8,
    parameter bit                CONT_PHASE = 1'b1
) (
    input  logic                       CLOCK,
    input  logic                       RESET_N,
    input  logic                       ENABLE,
    input  logic                       MODE,
    input  logic [BPS-1:0]             DIN,
    input  logic                       DIN_VALID,
    output logic                       DIN_READY,
    output logic                       STROBE,
    output logic                       SHIFT,
    output logic [$clog2(SYM_LEN)-1:0] COUNT,
    output logic [LFSR_W-1:0]          LFSR,
    output logic [BPS-1:0]             SYMBOL,
    output logic                       UNDERRUN,
    output logic                       DOUTREAL,
    output logic                       DOUTIMAG
);

    localparam int unsigned          CNT_W    = $clog2(SYM_LEN);
    localparam int unsigned          DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SYM_LEN - 1);
    localparam logic [PHASE_W-1:0]   BASE     = PHASE_W'(BASE_INC);
    localparam logic [PHASE_W-1:0]   STEP     = PHASE_W'(STEP_INC);

    logic [DIV_W-1:0]   div_q,      div_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic [PHASE_W-1:0] phase_q,    phase_d;
    logic [BPS-1:0]     symbol_q,   symbol_d;
    logic [LFSR_W-1:0]  lfsr_q,     lfsr_d;
    logic               underrun_q, underrun_d;

    logic               strobe;
    logic               shift;
    logic [PHASE_W-1:0] inc;
    logic [LFSR_W-1:0]  lfsr_adv;

    // An all-zero register would lock up, so it restarts from 1 instead of shifting.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        lfsr_step = (s == '0) ? LFSR_W'(1) : {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

    assign strobe = RESET_N && ENABLE && (div_q == DIV_LAST);
    assign shift  = strobe && (count_q == CNT_LAST);
    assign inc    = BASE + STEP * PHASE_W'(symbol_q);

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        div_d      = div_q;
        count_d    = count_q;
        phase_d    = phase_q;
        symbol_d   = symbol_q;
        lfsr_d     = lfsr_q;
        underrun_d = underrun_q;

        lfsr_adv = lfsr_q;
        for (int unsigned i = 0; i < BPS; i++) begin
            lfsr_adv = lfsr_step(lfsr_adv);
        end

        if (ENABLE) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end

        if (strobe) begin
            phase_d = phase_q + inc;
            count_d = (count_q == CNT_LAST) ? '0 : count_q + CNT_W'(1);
        end

        // The symbol boundary loads the tone used from the next sample onward.
        if (shift) begin
            if (!CONT_PHASE) begin
                phase_d = '0;
            end
            if (MODE) begin
                if (DIN_VALID) begin
                    symbol_d = DIN;
                end else begin
                    symbol_d   = '0;
                    underrun_d = 1'b1;
                end
            end else begin
                lfsr_d   = lfsr_adv;
                symbol_d = lfsr_adv[BPS-1:0];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            div_q      <= '0;
            count_q    <= '0;
            phase_q    <= '0;
            symbol_q   <= '0;
            lfsr_q     <= SEED;
            underrun_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            count_q    <= count_d;
            phase_q    <= phase_d;
            symbol_q   <= symbol_d;
            lfsr_q     <= lfsr_d;
            underrun_q <= underrun_d;
        end
    end

    assign STROBE    = strobe;
    assign SHIFT     = shift;
    assign DIN_READY = shift && MODE;
    assign COUNT     = count_q;
    assign LFSR      = lfsr_q;
    assign SYMBOL    = symbol_q;
    assign UNDERRUN  = underrun_q;
    // Sign outputs read high while reset is held, independent of the accumulator.
    assign DOUTIMAG  = !RESET_N || !phase_q[PHASE_W-1];
    assign DOUTREAL  = !RESET_N || !(phase_q[PHASE_W-1] ^ phase_q[PHASE_W-2]);

endmodule

// File: tb/tb_mfsk_mod.sv
// Directed bench for mfsk_mod: default build (a) and a 4-tone, divided, phase-reset build (b).
module tb_mfsk_mod;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable_a, enable_b;
    logic       mode;
    logic [0:0] din_a;
    logic       din_valid;
    logic [1:0] din_b = 2'd0;
    logic       mode_b = 1'b0;
    logic       din_valid_b = 1'b0;

    logic       din_ready_a, strobe_a, shift_a, underrun_a, doutreal_a, doutimag_a;
    logic [6:0] count_a;
    logic [4:0] lfsr_a;
    logic [0:0] symbol_a;

    logic       din_ready_b, strobe_b, shift_b, underrun_b, doutreal_b, doutimag_b;
    logic [2:0] count_b;
    logic [4:0] lfsr_b;
    logic [1:0] symbol_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mfsk_mod dut_a (
        .CLOCK(clk), .RESET_N(rst_n), .ENABLE(enable_a), .MODE(mode),
        .DIN(din_a), .DIN_VALID(din_valid), .DIN_READY(din_ready_a),
        .STROBE(strobe_a), .SHIFT(shift_a), .COUNT(count_a), .LFSR(lfsr_a),
        .SYMBOL(symbol_a), .UNDERRUN(underrun_a),
        .DOUTREAL(doutreal_a), .DOUTIMAG(doutimag_a)
    );

    mfsk_mod #(.CLK_DIV(4), .SYM_LEN(8), .BPS(2), .CONT_PHASE(1'b0)) dut_b (
        .CLOCK(clk), .RESET_N(rst_n), .ENABLE(enable_b), .MODE(mode_b),
        .DIN(din_b), .DIN_VALID(din_valid_b), .DIN_READY(din_ready_b),
        .STROBE(strobe_b), .SHIFT(shift_b), .COUNT(count_b), .LFSR(lfsr_b),
        .SYMBOL(symbol_b), .UNDERRUN(underrun_b),
        .DOUTREAL(doutreal_b), .DOUTIMAG(doutimag_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (strobe_a !== 1'b0 || shift_a !== 1'b0 || din_ready_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: strobe=%b shift=%b ready=%b want 000", strobe_a, shift_a, din_ready_a);
        end
        checks++;
        if (doutreal_a !== 1'b1 || doutimag_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_dout: real=%b imag=%b want 11", doutreal_a, doutimag_a);
        end
        checks++;
        if (count_a !== 7'd0 || lfsr_a !== 5'b00001 || symbol_a !== 1'b0 || underrun_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_a: count=%0d lfsr=%b sym=%0d und=%b want 0 00001 0 0",
                     count_a, lfsr_a, symbol_a, underrun_a);
        end
        checks++;
        if (strobe_b !== 1'b0 || count_b !== 3'd0 || lfsr_b !== 5'b00001 || symbol_b !== 2'd0) begin
            errors++;
            $display("FAIL reset_state_b: strobe=%b count=%0d lfsr=%b sym=%0d want 0 0 00001 0",
                     strobe_b, count_b, lfsr_b, symbol_b);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (strobe_a !== 1'b1 || strobe_b !== 1'b0) begin
            errors++;
            $display("FAIL first_strobe: a=%b b=%b want a=1 b=0 in cycle 1", strobe_a, strobe_b);
        end
    endtask

    task automatic test_lfsr_dout();
        logic [4:0] exp_lfsr [5] = '{5'b00010, 5'b00100, 5'b01001, 5'b10010, 5'b00101};
        logic       exp_sym  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] ph = 8'd0;
        logic       sym = 1'b0;
        int no_strobe = 0, bad_shift = 0, bad_rdy = 0, bad_dout = 0;
        mode = 1'b0;
        for (int k = 0; k < 5; k++) begin
            for (int n = 1; n <= 128; n++) begin
                if (strobe_a !== 1'b1) no_strobe++;
                if (shift_a !== (n == 128)) bad_shift++;
                if (din_ready_a !== 1'b0) bad_rdy++;
                if (doutimag_a !== ~ph[7] || doutreal_a !== ~(ph[7] ^ ph[6])) bad_dout++;
                if (n == 128) begin
                    checks++;
                    if (count_a !== 7'd127) begin
                        errors++;
                        $display("FAIL count_last sym%0d: got %0d want 127", k, count_a);
                    end
                end
                ph = ph + (sym ? 8'd16 : 8'd8);
                step();
            end
            checks++;
            if (lfsr_a !== exp_lfsr[k] || symbol_a !== exp_sym[k] || count_a !== 7'd0) begin
                errors++;
                $display("FAIL lfsr_seq shift%0d: lfsr=%b sym=%0d count=%0d want %b %0d 0",
                         k, lfsr_a, symbol_a, count_a, exp_lfsr[k], exp_sym[k]);
            end
            sym = exp_sym[k];
        end
        checks++;
        if (no_strobe != 0) begin
            errors++;
            $display("FAIL strobe_every_cycle: %0d cycles without strobe, want 0", no_strobe);
        end
        checks++;
        if (bad_shift != 0) begin
            errors++;
            $display("FAIL shift_timing: %0d wrong cycles, want 0", bad_shift);
        end
        checks++;
        if (bad_rdy != 0) begin
            errors++;
            $display("FAIL ready_in_lfsr_mode: %0d high cycles, want 0", bad_rdy);
        end
        checks++;
        if (bad_dout != 0) begin
            errors++;
            $display("FAIL dout_pattern_a: %0d wrong samples, want 0", bad_dout);
        end
    endtask

    task automatic test_din();
        logic vld_v [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic din_v [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic sym_v [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic und_v [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int  n, rdy, bad;
        bit  seen;
        mode = 1'b1;
        for (int k = 0; k < 5; k++) begin
            din_valid = vld_v[k];
            din_a     = din_v[k];
            n = 0; rdy = 0; bad = 0; seen = 1'b0;
            while (!seen && n < 200) begin
                n++;
                if (din_ready_a === 1'b1) begin
                    rdy++;
                    if (shift_a !== 1'b1) bad++;
                end
                if (shift_a === 1'b1) seen = 1'b1;
                else step();
            end
            checks++;
            if (!seen || n != 128 || rdy != 1 || bad != 0) begin
                errors++;
                $display("FAIL din_ready bnd%0d: shift at %0d ready_count=%0d stray=%0d want 128 1 0",
                         k, n, rdy, bad);
            end
            step();
            checks++;
            if (symbol_a !== sym_v[k] || underrun_a !== und_v[k] || lfsr_a !== 5'b00101) begin
                errors++;
                $display("FAIL din_load bnd%0d: sym=%0d und=%b lfsr=%b want %0d %b 00101",
                         k, symbol_a, underrun_a, lfsr_a, sym_v[k], und_v[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int  sa = 0, sb = 0;
        din_valid = 1'b1;
        din_a     = 1'b1;
        repeat (40) step();
        rst_n = 1'b0;
        step();
        checks++;
        if (count_a !== 7'd0 || symbol_a !== 1'b0 || lfsr_a !== 5'b00001 || underrun_a !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: count=%0d sym=%0d lfsr=%b und=%b want 0 0 00001 0",
                     count_a, symbol_a, lfsr_a, underrun_a);
        end
        checks++;
        if (din_ready_a !== 1'b0 || strobe_a !== 1'b0 || doutreal_a !== 1'b1 || doutimag_a !== 1'b1) begin
            errors++;
            $display("FAIL midreset_outputs: ready=%b strobe=%b real=%b imag=%b want 0 0 1 1",
                     din_ready_a, strobe_a, doutreal_a, doutimag_a);
        end
        step();
        rst_n = 1'b1;
        mode  = 1'b0;
        #1;
        for (int n = 1; n <= 200 && sa == 0; n++) begin
            if (shift_b === 1'b1 && sb == 0) sb = n;
            if (shift_a === 1'b1) sa = n;
            else step();
        end
        checks++;
        if (sa != 128 || sb != 32) begin
            errors++;
            $display("FAIL midreset_first_shift: a=%0d b=%0d want 128 32", sa, sb);
        end
        step();
        checks++;
        if (lfsr_a !== 5'b00010 || underrun_a !== 1'b0) begin
            errors++;
            $display("FAIL midreset_after_shift: lfsr=%b und=%b want 00010 0", lfsr_a, underrun_a);
        end
    endtask

    task automatic test_div_sym();
        logic [4:0] exp_l [10] = '{5'b00100, 5'b10010, 5'b01011, 5'b01100, 5'b10011,
                                   5'b01111, 5'b11110, 5'b11000, 5'b00011, 5'b01101};
        logic [1:0] exp_s [10] = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd3, 2'd3, 2'd2, 2'd0, 2'd3, 2'd1};
        logic [1:0] sym = 2'd0;
        logic [7:0] inc, ph;
        int bad_strobe = 0, bad_shift = 0, bad_dout = 0;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            inc = 8'd8 + 8'd8 * 8'(sym);
            for (int c = 1; c <= 32; c++) begin
                ph = 8'((c - 1) / 4) * inc;
                if (strobe_b !== (c % 4 == 0)) bad_strobe++;
                if (shift_b !== (c == 32)) bad_shift++;
                if (doutimag_b !== ~ph[7] || doutreal_b !== ~(ph[7] ^ ph[6])) bad_dout++;
                step();
            end
            checks++;
            if (lfsr_b !== exp_l[k] || symbol_b !== exp_s[k] || count_b !== 3'd0) begin
                errors++;
                $display("FAIL b_symbol shift%0d: lfsr=%b sym=%0d count=%0d want %b %0d 0",
                         k, lfsr_b, symbol_b, count_b, exp_l[k], exp_s[k]);
            end
            sym = exp_s[k];
        end
        checks++;
        if (bad_strobe != 0 || bad_shift != 0) begin
            errors++;
            $display("FAIL b_timing: strobe errs=%0d shift errs=%0d want 0 0", bad_strobe, bad_shift);
        end
        checks++;
        if (bad_dout != 0) begin
            errors++;
            $display("FAIL b_dout_phase: %0d wrong samples, want 0", bad_dout);
        end
    endtask

    task automatic test_enable();
        logic held_re, held_im;
        int   leak = 0, first_strobe = -1, first_shift = -1;
        do_reset();
        repeat (15) step();
        checks++;
        if (strobe_b !== 1'b1 || count_b !== 3'd3) begin
            errors++;
            $display("FAIL pre_freeze: strobe=%b count=%0d want 1 3", strobe_b, count_b);
        end
        enable_b = 1'b0;
        #1;
        held_re = doutreal_b;
        held_im = doutimag_b;
        repeat (10) begin
            if (strobe_b !== 1'b0 || shift_b !== 1'b0 || din_ready_b !== 1'b0) leak++;
            if (doutreal_b !== held_re || doutimag_b !== held_im) leak++;
            step();
        end
        checks++;
        if (leak != 0) begin
            errors++;
            $display("FAIL freeze_outputs: %0d active cycles, want 0", leak);
        end
        checks++;
        if (count_b !== 3'd3 || lfsr_b !== 5'b00001 || symbol_b !== 2'd0) begin
            errors++;
            $display("FAIL freeze_state: count=%0d lfsr=%b sym=%0d want 3 00001 0", count_b, lfsr_b, symbol_b);
        end
        enable_b = 1'b1;
        #1;
        for (int k = 0; k <= 40 && first_shift < 0; k++) begin
            if (strobe_b === 1'b1 && first_strobe < 0) first_strobe = k;
            if (shift_b === 1'b1) first_shift = k;
            else step();
        end
        checks++;
        if (first_strobe != 0 || first_shift != 16) begin
            errors++;
            $display("FAIL resume_timing: strobe at %0d shift at %0d want 0 16", first_strobe, first_shift);
        end
        step();
        checks++;
        if (lfsr_b !== 5'b00100 || symbol_b !== 2'd0) begin
            errors++;
            $display("FAIL resume_shift: lfsr=%b sym=%0d want 00100 0", lfsr_b, symbol_b);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        enable_a  = 1'b1;
        enable_b  = 1'b1;
        mode      = 1'b0;
        din_a     = 1'b0;
        din_valid = 1'b0;
        test_reset();
        test_lfsr_dout();
        test_din();
        test_reset_mid();
        test_div_sym();
        test_enable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mfsk_mod.md
# mfsk_mod

Parametrised M-ary FSK modulator: the next-generation replacement for the fixed binary FSK datapath (sample clock generator, symbol lookup, LFSR). It produces 1-bit quadrature (I/Q sign) outputs from a phase accumulator. Each symbol selects one of 2^BPS tones. Symbols come either from an internal configurable Fibonacci LFSR or from an external valid/ready data stream. It sits between the sample-rate divider domain and the GPIO output pins.

## Interface
- CLK_DIV, 1: clock cycles per sample strobe (≥1).
- SYM_LEN, 128: samples per symbol (≥2).
- BPS, 1: bits per symbol (1..3); tone count 2^BPS.
- LFSR_W, 5: LFSR width (3..16).
- LFSR_TAPS, 5'b10100: feedback tap mask (bit i set ⇒ state[i] in XOR).
- SEED, 5'b00001: LFSR reset value.
- PHASE_W, 8: phase accumulator width.
- BASE_INC, 8: phase increment for tone 0.
- STEP_INC, 8: increment added per tone index.
- CONT_PHASE, 1: 1 = continuous phase; 0 = phase cleared at symbol boundary.
- CLOCK  in  1  system clock; all logic rising-edge.
- RESET_N  in  1  synchronous, active-low reset.
- ENABLE  in  1  run; low freezes all state.
- MODE  in  1  0 = LFSR source, 1 = external DIN source.
- DIN  in  BPS  external symbol.
- DIN_VALID  in  1  DIN valid.
- DIN_READY  out  1  block accepts DIN this cycle.
- STROBE  out  1  sample strobe (one-cycle pulse).
- SHIFT  out  1  last sample of current symbol.
- COUNT  out  ceil(log2(SYM_LEN))  sample index within symbol.
- LFSR  out  LFSR_W  LFSR state.
- SYMBOL  out  BPS  current tone index.
- UNDERRUN  out  1  sticky external-data starvation flag.
- DOUTREAL  out  1  I sign.
- DOUTIMAG  out  1  Q sign.

## Operation
- Divider div_cnt counts 0..CLK_DIV-1 while ENABLE=1. It wraps to 0.
- STROBE = ENABLE && div_cnt==CLK_DIV-1. It is combinational from registers.
- Rising edge with STROBE=1:
  - phase ← phase + inc, modulo 2^PHASE_W.
  - inc = BASE_INC + SYMBOL*STEP_INC, truncated to PHASE_W.
  - COUNT ← COUNT+1, wrapping SYM_LEN-1→0.
- SHIFT = STROBE && COUNT==SYM_LEN-1. At that edge (symbol boundary):
  - MODE=0: the LFSR advances BPS single steps in one cycle; SYMBOL ← new LFSR[BPS-1:0].
  - MODE=1: DIN_READY=1 for that cycle. If DIN_VALID, SYMBOL ← DIN. Otherwise SYMBOL ← 0 and UNDERRUN ← 1. The LFSR holds.
  - CONT_PHASE=0: phase ← 0 instead of the normal update.
- DIN_READY = SHIFT && MODE. It is never high otherwise. MODE is only sampled at SHIFT edges.
- LFSR step: fb = XOR(state & LFSR_TAPS); state ← {state[LFSR_W-2:0], fb}. An all-zero state is replaced by 1 on its next step (lock-up escape).
- DOUTIMAG = ~phase[PHASE_W-1] (sin ≥ 0).
- DOUTREAL = ~(phase[PHASE_W-1] ^ phase[PHASE_W-2]) (cos ≥ 0).
- UNDERRUN clears only on reset.

## Timing
- Reset (RESET_N=0 at an edge) sets div_cnt=0, COUNT=0, phase=0, SYMBOL=0, LFSR=SEED, UNDERRUN=0.
- Output values during reset: STROBE=0, SHIFT=0, DIN_READY=0, DOUTREAL=1, DOUTIMAG=1.
- Reset mid-symbol aborts the symbol. No DIN is consumed.
- First STROBE is in cycle CLK_DIV after reset release (cycle 1 when CLK_DIV=1).
- First SHIFT is in cycle CLK_DIV*SYM_LEN after reset release.
- Symbol and increment changes take effect from the first sample of the next symbol. Zero-cycle gap between symbols.
- ENABLE=0 holds div_cnt, COUNT, phase, LFSR and SYMBOL, and forces STROBE/SHIFT/DIN_READY low. On resume, div_cnt continues from its held value.
- DOUT* change only on the edge following a STROBE.

## Test plan
- Defaults, MODE=0, ENABLE=1 after reset -> STROBE high every cycle; first SHIFT at cycle 128, COUNT 127→0. LFSR sequence at successive SHIFT edges: 00010, 00100, 01001, 10010, 00101. SYMBOL: 0, 0, 1, 0, 1.
- Defaults, SYMBOL=0 -> DOUTIMAG 16 samples high / 16 low. DOUTREAL 8 high, 16 low, 8 high (period 32). SYMBOL=1 gives half the period, and phase is continuous across the boundary.
- MODE=1, DIN_VALID=1, DIN=1 held -> DIN_READY exactly one cycle per 128, coincident with SHIFT. SYMBOL=1 from the next symbol; UNDERRUN stays 0.
- MODE=1, DIN_VALID=0 at a boundary -> SYMBOL=0 and UNDERRUN=1. UNDERRUN remains 1 after valid data resumes, until RESET_N=0.
- CLK_DIV=4, SYM_LEN=8, BPS=2, CONT_PHASE=0 -> STROBE every 4th cycle; SHIFT at cycle 32. Phase is zero at the start of each symbol. SYMBOL takes values 0..3 with the matching increment (8 + 8·SYMBOL).
- ENABLE low for 10 cycles mid-symbol, and separately RESET_N low mid-symbol -> ENABLE low: all state frozen, then resumes with no lost samples. RESET_N low: reset values on the next edge, and the first SHIFT again at CLK_DIV·SYM_LEN after release.
